// File: rtl/clock_div_prog.sv
// Multi-channel run-time programmable clock divider; every flop on `clock`, no derived clocks.
// Optional phase-align input `sync` is built only when CLOCK_DIV_PROG_SYNC_EN is defined.
module clock_div_prog #(
  parameter int NUM_CH      = 4,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 4,
  parameter bit AUTO_START  = 1'b0,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [WIDTH-1:0]  wr_div,
  input  logic              wr_run,
`ifdef CLOCK_DIV_PROG_SYNC_EN
  input  logic              sync,
`endif
  output logic [NUM_CH-1:0] div_clock,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] running,
  output logic [NUM_CH-1:0] pending
);

  typedef struct packed {
    logic             run;
    logic             pend;
    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] pdiv;
  } chan_t;

  localparam chan_t RESET_STATE = '{
    run:  AUTO_START,
    pend: 1'b0,
    div:  WIDTH'(DEFAULT_DIV),
    cnt:  '0,
    pdiv: '0
  };

  chan_t             ch_q [NUM_CH];
  chan_t             ch_d [NUM_CH];
  logic [NUM_CH-1:0] div_clock_d;
  logic [NUM_CH-1:0] tick_d;

  // Divisors 0 and 1 behave as 2, so a period is never shorter than two cycles.
  function automatic logic [WIDTH-1:0] eff_div(input logic [WIDTH-1:0] d);
    return (d < WIDTH'(2)) ? WIDTH'(2) : d;
  endfunction

  // (E+1)>>1 computed one bit wider so E = 2^WIDTH-1 does not wrap to zero.
  function automatic logic [WIDTH-1:0] half_div(input logic [WIDTH-1:0] e);
    logic [WIDTH:0] s;
    s = {1'b0, e} + (WIDTH+1)'(1);
    return s[WIDTH:1];
  endfunction

  always_comb begin : next_state
    chan_t            nxt;
    logic [WIDTH-1:0] e_cur;
    logic [WIDTH-1:0] e_nxt;
    logic             wrap;
    logic             hit;
    // NOTE: combinational logic uses blocking '=', and every output gets a default
    // before any branch so no path leaves a value held (which would infer a latch).
    nxt         = '0;
    e_cur       = '0;
    e_nxt       = '0;
    wrap        = 1'b0;
    hit         = 1'b0;
    div_clock_d = '0;
    tick_d      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      nxt   = ch_q[i];
      e_cur = eff_div(ch_q[i].div);
      wrap  = ch_q[i].run && (ch_q[i].cnt == e_cur - WIDTH'(1));
      // Out-of-range channel numbers match no index and are dropped here.
      hit   = wr_en && (int'(wr_ch) == i);

      if (hit && !ch_q[i].run) begin
        nxt.div = wr_div;
        if (wr_run) begin
          nxt.run  = 1'b1;
          nxt.cnt  = '0;
          nxt.pend = 1'b0;
        end
      end else if (hit && !wr_run) begin
        nxt.run  = 1'b0;
        nxt.cnt  = '0;
        nxt.div  = wr_div;
        nxt.pend = 1'b0;
      end
`ifdef CLOCK_DIV_PROG_SYNC_EN
      else if (hit && sync) begin
        nxt.div  = wr_div;
        nxt.cnt  = '0;
        nxt.pend = 1'b0;
      end else if (sync && ch_q[i].run) begin
        nxt.cnt = '0;
        if (ch_q[i].pend) begin
          nxt.div  = ch_q[i].pdiv;
          nxt.pend = 1'b0;
        end
      end
`endif
      else if (ch_q[i].run) begin
        nxt.cnt = wrap ? '0 : ch_q[i].cnt + WIDTH'(1);
        if (wrap && ch_q[i].pend) begin
          nxt.div  = ch_q[i].pdiv;
          nxt.pend = 1'b0;
        end
        // A write on the wrap cycle is queued behind the value applied above.
        if (hit) begin
          nxt.pdiv = wr_div;
          nxt.pend = 1'b1;
        end
      end

      ch_d[i] = nxt;
      // Outputs are decoded from next state so the registered copies line up with cnt.
      e_nxt          = eff_div(nxt.div);
      div_clock_d[i] = nxt.run && (nxt.cnt < half_div(e_nxt));
      tick_d[i]      = nxt.run && (nxt.cnt == e_nxt - WIDTH'(1));
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so all flops update from the same
  // pre-edge values; the per-channel registers are control state and all get reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= RESET_STATE;
      div_clock <= {NUM_CH{AUTO_START}};
      tick      <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= ch_d[i];
      div_clock <= div_clock_d;
      tick      <= tick_d;
    end
  end

  always_comb begin
    running = '0;
    pending = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      running[i] = ch_q[i].run;
      pending[i] = ch_q[i].pend;
    end
  end

endmodule
